// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 UART receiver driven by a shared OVERSAMPLE x baud sample_enable tick.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting at ticks M-1..M+1; the default build samples once at M+1.
module uart_rx_fsm #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       system_clock,
  input  logic       rst,
  input  logic       sample_enable,
  input  logic       Rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_error
);
  // state | meaning
  // IDLE  | waiting for a falling edge on the synchronized line
  // START | start bit, a full bit period; high at the decision tick is a false start
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit; ends at the decision tick so back-to-back frames are caught
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam logic [TW-1:0] TICK_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, data_d;
  logic          busy_d, valid_d, ferr_d;
  logic          rx_meta, rx_s, rx_prev;
  logic          bit_val, is_dec, is_last;

  always_ff @(posedge system_clock) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge system_clock) begin
    if (rst)                rx_prev <= 1'b1;
    else if (sample_enable) rx_prev <= rx_s;
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] TICK_VOTE_A = TW'(M - 1);
  localparam logic [TW-1:0] TICK_VOTE_B = TW'(M);
  logic vote_a, vote_b;

  always_ff @(posedge system_clock) begin
    if (rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (sample_enable) begin
      if (tick_q == TICK_VOTE_A) vote_a <= rx_s;
      if (tick_q == TICK_VOTE_B) vote_b <= rx_s;
    end
  end

  assign bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign bit_val = rx_s;
`endif

  assign is_dec  = (tick_q == TICK_DEC);
  assign is_last = (tick_q == TICK_LAST);

  always_ff @(posedge system_clock) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_out    <= '0;
      rx_valid    <= 1'b0;
      rx_busy     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_out    <= data_d;
      rx_valid    <= valid_d;
      rx_busy     <= busy_d;
      frame_error <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_out;
    busy_d  = rx_busy;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (sample_enable) begin
      tick_d = is_last ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_d = '0;
          if (rx_prev && !rx_s) begin
            state_d = START;
            busy_d  = 1'b1;
          end
        end
        START: begin
          if (is_dec && bit_val) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (is_last) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (is_dec) shift_d = {bit_val, shift_q[7:1]};
          if (is_last) begin
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 1'b1;
          end
        end
        STOP: begin
          if (is_dec) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (bit_val) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: randomized-timing stimulus for uart_rx_fsm, checked every cycle against a
// frame-level model (sample positions computed from the detected start edge), plus literal checks.
module tb_uart_rx_fsm;
  localparam int OS = 16;
  localparam int M  = OS / 2;

  logic       system_clock = 1'b0;
  logic       rst = 1'b1;
  logic       sample_enable = 1'b0;
  logic       Rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid, rx_busy, frame_error;

  uart_rx_fsm #(.OVERSAMPLE(OS)) dut (
    .system_clock (system_clock),
    .rst          (rst),
    .sample_enable(sample_enable),
    .Rx           (Rx),
    .data_out     (data_out),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .frame_error  (frame_error)
  );

  always #5 system_clock = ~system_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the line value seen at each enable, and the expected outputs after each edge.
  bit         line_h[$];
  bit         m_prev = 1'b1, m_busy = 1'b0, m_valid = 1'b0, m_fe = 1'b0;
  logic [7:0] m_data = 8'h00, m_byte = 8'h00;
  int         m_det = 0;

  function automatic bit sample_at(input int e);
`ifdef UART_RX_MAJORITY_EN
    int ones;
    ones = int'(line_h[e-2]) + int'(line_h[e-1]) + int'(line_h[e]);
    return (ones >= 2);
`else
    return line_h[e];
`endif
  endfunction

  // Bit b of a frame (0 = start, 9 = stop) is judged at enable det + 1 + OS*b + M + 1.
  always @(posedge system_clock) begin : model
    int e, rel, b;
    bit cur, s;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    if (rst) begin
      m_prev = 1'b1;
      m_busy = 1'b0;
      m_data = 8'h00;
    end else if (sample_enable) begin
      cur = Rx;
      line_h.push_back(cur);
      e = line_h.size() - 1;
      if (!m_busy) begin
        if (m_prev && !cur) begin
          m_busy = 1'b1;
          m_det  = e;
        end
      end else begin
        rel = e - m_det - 1;
        if (rel % OS == M + 1) begin
          b = rel / OS;
          s = sample_at(e);
          if (b == 0) begin
            if (s) m_busy = 1'b0;
          end else if (b <= 8) begin
            m_byte[b-1] = s;
          end else begin
            m_busy = 1'b0;
            if (s) begin
              m_valid = 1'b1;
              m_data  = m_byte;
            end else begin
              m_fe = 1'b1;
            end
          end
        end
      end
      m_prev = cur;
    end
  end

  bit         checking = 1'b0;
  int         tot_valid = 0, tot_fe = 0;
  logic [7:0] got_q[$];

  always @(negedge system_clock) begin
    if (checking) begin
      chk("rx_valid", rx_valid, m_valid);
      chk("frame_error", frame_error, m_fe);
      chk("rx_busy", rx_busy, m_busy);
      chk("data_out", data_out, m_data);
      chk("valid_fe_exclusive", rx_valid & frame_error, 1'b0);
      if (rx_valid === 1'b1) begin
        tot_valid++;
        got_q.push_back(data_out);
      end
      if (frame_error === 1'b1) tot_fe++;
    end
  end

  int busy_ticks = 0;

  // Rx changes at least two clocks before each enable, so the synchronizer has settled.
  task automatic tick(input bit v);
    int gap;
    gap = $urandom_range(4, 2);
    Rx = v;
    repeat (gap) @(negedge system_clock);
    sample_enable = 1'b1;
    @(negedge system_clock);
    sample_enable = 1'b0;
    if (rx_busy) busy_ticks++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int flip, input int limit);
    bit bits[10];
    bit v;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9] = stop;
    for (int t = 0; t < 10 * OS && t < limit; t++) begin
      v = bits[t / OS];
      if (t == flip) v = ~v;
      tick(v);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int bv, bf, good, gap;
    logic [7:0] d;
    bit stop;

    repeat (4) @(negedge system_clock);
    chk("reset data_out", data_out, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_busy", rx_busy, 1'b0);
    chk("reset frame_error", frame_error, 1'b0);
    rst = 1'b0;
    checking = 1'b1;
    idle(20);

    // Single frame 0xA5.
    bv = tot_valid; bf = tot_fe; busy_ticks = 0;
    send_frame(8'hA5, 1'b1, -1, 10 * OS);
    idle(4);
    chk("a5 valid count", tot_valid - bv, 1);
    chk("a5 data", got_q[bv], 8'hA5);
    chk("a5 fe count", tot_fe - bf, 0);
    chk("a5 busy ticks", busy_ticks, 9 * OS + M + 2);

    // Back-to-back 0x00, 0xFF with no idle gap.
    bv = tot_valid;
    send_frame(8'h00, 1'b1, -1, 10 * OS);
    send_frame(8'hFF, 1'b1, -1, 10 * OS);
    idle(4);
    chk("b2b valid count", tot_valid - bv, 2);
    chk("b2b first", got_q[bv], 8'h00);
    chk("b2b second", got_q[bv+1], 8'hFF);

    // Short low glitch: false start, then a good 0x3C.
    bv = tot_valid; bf = tot_fe; busy_ticks = 0;
    for (int i = 0; i < 4; i++) tick(1'b0);
    idle(20);
    chk("glitch valid count", tot_valid - bv, 0);
    chk("glitch fe count", tot_fe - bf, 0);
    chk("glitch busy ticks", busy_ticks, M + 2);
    send_frame(8'h3C, 1'b1, -1, 10 * OS);
    idle(4);
    chk("after glitch data", got_q[bv], 8'h3C);

    // Good 0x96, then 0x3C with a bad stop bit running into a 40-bit break, then 0x81.
    send_frame(8'h96, 1'b1, -1, 10 * OS);
    idle(4);
    bv = tot_valid; bf = tot_fe;
    send_frame(8'h3C, 1'b0, -1, 10 * OS);
    for (int i = 0; i < 40 * OS; i++) tick(1'b0);
    chk("break fe count", tot_fe - bf, 1);
    chk("break valid count", tot_valid - bv, 0);
    chk("break data held", data_out, 8'h96);
    chk("break busy", rx_busy, 1'b0);
    idle(OS);
    send_frame(8'h81, 1'b1, -1, 10 * OS);
    idle(4);
    chk("after break data", got_q[bv], 8'h81);

    // One-tick high glitch inside data bit 3 of 0x00 (line tick t is receiver tick t-1).
    bv = tot_valid;
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h00, 1'b1, 4 * OS + M + 1, 10 * OS);
    idle(4);
    chk("bit glitch data", got_q[bv], 8'h00);
`else
    send_frame(8'h00, 1'b1, 4 * OS + M + 2, 10 * OS);
    idle(4);
    chk("bit glitch data", got_q[bv], 8'h08);
`endif

    // Reset during data bit 4 of 0x5A, then resend.
    bv = tot_valid; bf = tot_fe;
    send_frame(8'h5A, 1'b1, -1, 5 * OS + 5);
    chk("abort busy", rx_busy, 1'b1);
    rst = 1'b1;
    Rx  = 1'b1;
    repeat (3) @(negedge system_clock);
    chk("abort data_out", data_out, 8'h00);
    chk("abort rx_busy", rx_busy, 1'b0);
    chk("abort rx_valid", rx_valid, 1'b0);
    chk("abort frame_error", frame_error, 1'b0);
    rst = 1'b0;
    chk("abort valid count", tot_valid - bv, 0);
    chk("abort fe count", tot_fe - bf, 0);
    idle(20);
    send_frame(8'h5A, 1'b1, -1, 10 * OS);
    idle(4);
    chk("resend data", got_q[bv], 8'h5A);

    // Random bytes, gaps and occasional bad stop bits.
    bv = tot_valid; good = 0;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom_range(255, 0));
      stop = ($urandom_range(5, 0) != 0);
      if (stop) good++;
      send_frame(d, stop, -1, 10 * OS);
      gap = stop ? $urandom_range(5, 0) : $urandom_range(5, 1);
      idle(gap);
    end
    idle(OS);
    chk("random good frames", tot_valid - bv, good);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Oversampling UART receiver: the receive-side counterpart of the team's UART transmit FSM. Recovers 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) from the serial line and presents each byte with a one-cycle valid strobe. It runs in the same `system_clock` domain and takes a shared 16x-baud `sample_enable` tick. It sits directly downstream of the transmitter's `Tx` pin, for loopback or external input.

## Interface
- `OVERSAMPLE`, 16: `sample_enable` ticks per bit period. Must be even and at least 8.
- `system_clock` input, 1: the only clock.
- `rst` input, 1: synchronous, active-high reset.
- `sample_enable` input, 1: one-cycle strobe at OVERSAMPLE x baud. All state advances only on cycles where it is 1.
- `Rx` input, 1: asynchronous serial line. Idle level is 1.
- `data_out` output, 8: last correctly framed byte. Holds until the next good frame.
- `rx_valid` output, 1: one-`system_clock` pulse when `data_out` updates.
- `rx_busy` output, 1: high while a frame is in progress.
- `frame_error` output, 1: one-cycle pulse when the stop bit is sampled 0.

## Operation
- `Rx` passes through a 2-flop synchronizer clocked every `system_clock`. `rx_s` denotes the synchronized output. `rx_prev` is `rx_s` registered on each `sample_enable`.
- `tick_cnt` has width `$clog2(OVERSAMPLE)` and counts 0..OVERSAMPLE-1 within each bit. `bit_cnt` is 3 bits. M = OVERSAMPLE/2.
- States and transitions:
  - **IDLE**: enter START on a `sample_enable` where `rx_prev`=1 and `rx_s`=0 (falling edge). Set `tick_cnt`=0 and `rx_busy`=1. A line held low never retriggers; a rising edge must be seen first.
  - **START**: at the decision tick, if the sample is 1 it is a false start: go to IDLE with `rx_busy`=0 and no other output. Otherwise go to DATA with `tick_cnt`=0 and `bit_cnt`=0.
  - **DATA**: at the decision tick, shift the sample into `shift_reg[7]` (right shift, so LSB arrives first). At `tick_cnt`=OVERSAMPLE-1, if `bit_cnt`=7 go to STOP, else increment `bit_cnt`. `tick_cnt` wraps OVERSAMPLE-1 to 0.
  - **STOP**: at the decision tick, go to IDLE immediately without waiting for the end of the bit. This permits back-to-back frames.
    - If the sample is 1: `data_out`<=`shift_reg`, pulse `rx_valid`.
    - If the sample is 0: pulse `frame_error` and leave `data_out` unchanged.
    - `rx_busy`<=0 in both cases.
- Decision tick is `tick_cnt`=M+1 (see Configuration).
- `rx_valid` and `frame_error` are never high together. Both deassert on the cycle after assertion, regardless of `sample_enable`.

## Timing
- Reset values: `data_out`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_error`=0, state IDLE. The synchronizer flops and `rx_prev` reset to 1.
- `rst` mid-frame aborts the frame with no `rx_valid` or `frame_error`. After reset the receiver needs a fresh falling edge.
- Input latency: 2 `system_clock` cycles (synchronizer), plus up to one `sample_enable` period of edge-detect quantization.
- `rx_valid` rises on the `system_clock` edge following the `sample_enable` cycle holding the STOP decision tick. That is about 9.5 bit periods after the start edge.
- `rx_busy` rises on the edge that registers the start detection. It falls together with `rx_valid` or `frame_error`, or on a false start.
- `sample_enable` low freezes all counters and state. Outputs hold, except the one-cycle pulses.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Samples are taken at ticks M-1, M and M+1 of each bit.
  - The bit value is the 2-of-3 majority, decided at tick M+1.
  - Single-tick glitches are rejected.
- `UART_RX_MAJORITY_EN` undefined:
  - A single sample is taken at tick M+1 and used directly.
  - No vote registers are built.
- State timing, decision tick and latency are identical in both builds.

## Test plan
- Byte 0xA5 at 16x with ideal timing -> exactly one `rx_valid` pulse, `data_out`=0xA5, `rx_busy` high about 9.5 bit periods, `frame_error` never 1.
- Back-to-back 0x00 then 0xFF with zero idle gap -> two `rx_valid` pulses, `data_out` 0x00 then 0xFF, no missed start.
- Rx low for 4 ticks then high (glitch start) -> no `rx_valid` or `frame_error`, `rx_busy` returns to 0 at tick M+1. A following 0x3C frame is then received correctly.
- Byte 0x3C with stop bit forced 0, then Rx held low 40 bit periods, then idle, then 0x81 -> one `frame_error` pulse, `data_out` unchanged during the break, no retrigger while low, then `rx_valid` with 0x81.
- Byte 0x00 with a 1-tick high glitch at tick M of bit 3 -> with `UART_RX_MAJORITY_EN`, `data_out`=0x00. Without it, a glitch at tick M+1 gives `data_out`=0x08.
- `rst` asserted during bit 4 of 0x5A, released, then 0x5A resent -> no output pulses during the aborted frame, all outputs at reset values, then `rx_valid` with 0x5A.
